// File: rtl/regfile_read_port.sv
// 8 x WIDTH register array with one one-hot write wordline and two registered
// read ports, including same-cycle write-to-read bypass and wordline checking.
module regfile_read_port #(
    parameter int WIDTH    = 16,
    parameter int ZERO_REG = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       Wordline,
    input  logic [WIDTH-1:0] WriteData,
    input  logic [2:0]       SrcReg1,
    input  logic [2:0]       SrcReg2,
    input  logic             ReadEn1,
    input  logic             ReadEn2,
    output logic [WIDTH-1:0] SrcData1,
    output logic [WIDTH-1:0] SrcData2,
    output logic             Valid1,
    output logic             Valid2,
    output logic             WlErr
);

    // Handshake: no back-pressure. ValidN is high for exactly the cycle after
    // an edge where ReadEnN was sampled high; SrcDataN holds between requests.

    logic [WIDTH-1:0] regs [8];
    logic [WIDTH-1:0] fwd  [8];
    logic [7:0]       we;
    logic [7:0]       rd_sel1;
    logic [7:0]       rd_sel2;
    logic [WIDTH-1:0] rd_val1;
    logic [WIDTH-1:0] rd_val2;
    logic             wl_nonzero;
    logic             wl_onehot;
    logic             wl_multi;

    assign wl_nonzero = (Wordline != 8'h00);
    assign wl_onehot  = wl_nonzero && ((Wordline & (Wordline - 8'd1)) == 8'h00);
    assign wl_multi   = wl_nonzero && !wl_onehot;

    // Register 0 is never written when hardwired, so it also never bypasses.
    always_comb begin
        we = 8'h00;
        for (int i = 0; i < 8; i++) begin
            we[i] = wl_onehot && Wordline[i] && !((ZERO_REG != 0) && (i == 0));
        end
    end

    always_comb begin
        for (int i = 0; i < 8; i++) begin
            fwd[i] = we[i] ? WriteData : regs[i];
            if ((ZERO_REG != 0) && (i == 0)) begin
                fwd[i] = '0;
            end
        end
    end

    assign rd_sel1 = 8'h01 << SrcReg1;
    assign rd_sel2 = 8'h01 << SrcReg2;

    // One-hot AND-OR selection keeps both read muxes flat and identical.
    always_comb begin
        rd_val1 = '0;
        rd_val2 = '0;
        for (int i = 0; i < 8; i++) begin
            rd_val1 = rd_val1 | (fwd[i] & {WIDTH{rd_sel1[i]}});
            rd_val2 = rd_val2 | (fwd[i] & {WIDTH{rd_sel2[i]}});
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (we[i]) begin
                    regs[i] <= WriteData;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            SrcData1 <= '0;
            Valid1   <= 1'b0;
        end else begin
            if (ReadEn1) begin
                SrcData1 <= rd_val1;
            end
            Valid1 <= ReadEn1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            SrcData2 <= '0;
            Valid2   <= 1'b0;
        end else begin
            if (ReadEn2) begin
                SrcData2 <= rd_val2;
            end
            Valid2 <= ReadEn2;
        end
    end

    // Sticky until reset; a legal write afterwards does not clear it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            WlErr <= 1'b0;
        end else if (wl_multi) begin
            WlErr <= 1'b1;
        end
    end

endmodule

// File: tb/tb_regfile_read_port.sv
// Directed bench for regfile_read_port: two instances differing only in ZERO_REG.
module tb_regfile_read_port;

    localparam int WIDTH = 16;

    logic             clk;
    logic             rst_n;
    logic [7:0]       Wordline;
    logic [WIDTH-1:0] WriteData;
    logic [2:0]       SrcReg1;
    logic [2:0]       SrcReg2;
    logic             ReadEn1;
    logic             ReadEn2;
    logic [WIDTH-1:0] SrcData1, SrcData2, nz_SrcData1, nz_SrcData2;
    logic             Valid1, Valid2, nz_Valid1, nz_Valid2;
    logic             WlErr, nz_WlErr;

    int checks = 0;
    int errors = 0;

    regfile_read_port #(.WIDTH(WIDTH), .ZERO_REG(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .Wordline(Wordline), .WriteData(WriteData),
        .SrcReg1(SrcReg1), .SrcReg2(SrcReg2), .ReadEn1(ReadEn1), .ReadEn2(ReadEn2),
        .SrcData1(SrcData1), .SrcData2(SrcData2), .Valid1(Valid1), .Valid2(Valid2),
        .WlErr(WlErr)
    );

    regfile_read_port #(.WIDTH(WIDTH), .ZERO_REG(0)) u_dut_nz (
        .clk(clk), .rst_n(rst_n), .Wordline(Wordline), .WriteData(WriteData),
        .SrcReg1(SrcReg1), .SrcReg2(SrcReg2), .ReadEn1(ReadEn1), .ReadEn2(ReadEn2),
        .SrcData1(nz_SrcData1), .SrcData2(nz_SrcData2), .Valid1(nz_Valid1),
        .Valid2(nz_Valid2), .WlErr(nz_WlErr)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [WIDTH-1:0] obs,
                         input logic [WIDTH-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        Wordline  = 8'h00;
        WriteData = '0;
        ReadEn1   = 1'b0;
        ReadEn2   = 1'b0;
        SrcReg1   = 3'd0;
        SrcReg2   = 3'd0;
    endtask

    task automatic write_reg(input logic [7:0] wl, input logic [WIDTH-1:0] d);
        Wordline  = wl;
        WriteData = d;
        tick();
        Wordline  = 8'h00;
    endtask

    initial begin
        // reset with random inputs
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            Wordline  = 8'($urandom_range(0, 255));
            WriteData = 16'($urandom_range(0, 65535));
            SrcReg1   = 3'($urandom_range(0, 7));
            SrcReg2   = 3'($urandom_range(0, 7));
            ReadEn1   = 1'($urandom_range(0, 1));
            ReadEn2   = 1'($urandom_range(0, 1));
            tick();
        end
        check("rst_src1", SrcData1, 16'h0000);
        check("rst_src2", SrcData2, 16'h0000);
        check("rst_valid1", {15'd0, Valid1}, 16'd0);
        check("rst_valid2", {15'd0, Valid2}, 16'd0);
        check("rst_wlerr", {15'd0, WlErr}, 16'd0);
        check("rst_nz_wlerr", {15'd0, nz_WlErr}, 16'd0);
        idle();
        #3 rst_n = 1'b1;

        for (int r = 0; r < 8; r++) begin
            ReadEn1 = 1'b1; SrcReg1 = 3'(r);
            ReadEn2 = 1'b1; SrcReg2 = 3'(r);
            tick();
            check($sformatf("rst_read1_r%0d", r), SrcData1, 16'h0000);
            check($sformatf("rst_read2_r%0d", r), nz_SrcData2, 16'h0000);
            check($sformatf("rst_valid1_r%0d", r), {15'd0, Valid1}, 16'd1);
        end
        idle();
        tick();
        check("idle_valid1", {15'd0, Valid1}, 16'd0);

        // write then read
        write_reg(8'h08, 16'hBEEF);
        ReadEn1 = 1'b1; SrcReg1 = 3'd3;
        tick();
        check("wr_rd_data", SrcData1, 16'hBEEF);
        check("wr_rd_valid", {15'd0, Valid1}, 16'd1);
        ReadEn1 = 1'b0;
        tick();
        check("hold_data", SrcData1, 16'hBEEF);
        check("hold_valid", {15'd0, Valid1}, 16'd0);

        // bypass
        write_reg(8'h20, 16'h1111);
        Wordline = 8'h20; WriteData = 16'h2222;
        ReadEn1 = 1'b1; SrcReg1 = 3'd5;
        ReadEn2 = 1'b1; SrcReg2 = 3'd5;
        tick();
        idle();
        check("bypass_p1", SrcData1, 16'h2222);
        check("bypass_p2", SrcData2, 16'h2222);
        check("bypass_v2", {15'd0, Valid2}, 16'd1);
        ReadEn1 = 1'b1; SrcReg1 = 3'd5;
        tick();
        check("bypass_stored", SrcData1, 16'h2222);

        // zero register
        idle();
        write_reg(8'h01, 16'hFFFF);
        ReadEn2 = 1'b1; SrcReg2 = 3'd0;
        tick();
        check("zero_read", SrcData2, 16'h0000);
        check("zero_wlerr", {15'd0, WlErr}, 16'd0);
        check("nz_read", nz_SrcData2, 16'hFFFF);
        Wordline = 8'h01; WriteData = 16'h7777;
        tick();
        check("zero_bypass", SrcData2, 16'h0000);
        check("nz_bypass", nz_SrcData2, 16'h7777);
        idle();

        // illegal wordline
        write_reg(8'h02, 16'hAAAA);
        write_reg(8'h04, 16'hBBBB);
        Wordline = 8'h06; WriteData = 16'h1234;
        ReadEn1 = 1'b1; SrcReg1 = 3'd1;
        ReadEn2 = 1'b1; SrcReg2 = 3'd2;
        tick();
        check("ill_p1", SrcData1, 16'hAAAA);
        check("ill_p2", SrcData2, 16'hBBBB);
        check("ill_wlerr", {15'd0, WlErr}, 16'd1);
        check("ill_nz_wlerr", {15'd0, nz_WlErr}, 16'd1);
        Wordline = 8'h00;
        tick();
        check("ill_reg1_kept", SrcData1, 16'hAAAA);
        check("ill_reg2_kept", SrcData2, 16'hBBBB);
        Wordline = 8'h04; WriteData = 16'h4444;
        ReadEn1 = 1'b0;
        tick();
        check("legal_bypass_after_err", SrcData2, 16'h4444);
        check("wlerr_sticky", {15'd0, WlErr}, 16'd1);
        Wordline = 8'h00;
        tick();
        check("wlerr_sticky2", {15'd0, WlErr}, 16'd1);

        // async reset mid-operation
        idle();
        write_reg(8'h80, 16'h5A5A);
        ReadEn1 = 1'b1; SrcReg1 = 3'd7;
        tick();
        check("pre_arst_data", SrcData1, 16'h5A5A);
        check("pre_arst_valid", {15'd0, Valid1}, 16'd1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_data", SrcData1, 16'h0000);
        check("arst_valid", {15'd0, Valid1}, 16'd0);
        check("arst_wlerr", {15'd0, WlErr}, 16'd0);
        #2 rst_n = 1'b1;
        tick();
        check("post_arst_reg7", SrcData1, 16'h0000);
        check("post_arst_valid", {15'd0, Valid1}, 16'd1);
        check("post_arst_wlerr", {15'd0, WlErr}, 16'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
